// File: rtl/vga_pkg.sv
// Shared VGA definitions: default 640x480@60 timing, output modes, RGB332 bar palette
// and the delay-line payload.
package vga_pkg;

  localparam int H_ACTIVE_D = 640;
  localparam int H_FP_D     = 16;
  localparam int H_SYNC_D   = 96;
  localparam int H_BP_D     = 48;
  localparam int V_ACTIVE_D = 480;
  localparam int V_FP_D     = 10;
  localparam int V_SYNC_D   = 2;
  localparam int V_BP_D     = 33;

  typedef enum logic [1:0] {
    MODE_PASS  = 2'd0,
    MODE_FILL  = 2'd1,
    MODE_BARS  = 2'd2,
    MODE_BLANK = 2'd3
  } mode_e;

  // Everything that has to travel alongside the colour fetch
  typedef struct packed {
    logic       req;
    logic       hs;
    logic       vs;
    logic [2:0] bar;
  } dly_t;

  function automatic logic [7:0] bar_color(input logic [2:0] idx);
    case (idx)
      3'd0:    return 8'hFF;
      3'd1:    return 8'hFC;
      3'd2:    return 8'h1F;
      3'd3:    return 8'h1C;
      3'd4:    return 8'hE3;
      3'd5:    return 8'hE0;
      3'd6:    return 8'h03;
      default: return 8'h00;
    endcase
  endfunction

endpackage

// File: rtl/vga_if.sv
// Pixel request bus between the output stage (master) and the graphics controller (slave).
interface vga_if #(
  parameter int XW      = 10,
  parameter int YW      = 10,
  parameter int COLOR_W = 8
);
  logic [XW-1:0]      pix_x;
  logic [YW-1:0]      pix_y;
  logic               pix_req;
  logic               frame_start;
  logic [COLOR_W-1:0] color_data;

  modport master (output pix_x, pix_y, pix_req, frame_start, input color_data);
  modport slave  (input pix_x, pix_y, pix_req, frame_start, output color_data);
endinterface

// File: rtl/vga_timing_core.sv
// Raster counters plus raw (undelayed) sync, active-area, bar-index and frame_start decode.
module vga_timing_core #(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter bit HS_POL   = 1'b0,
  parameter bit VS_POL   = 1'b0,
  parameter int XW       = 10,
  parameter int YW       = 10
) (
  input  logic          pixel_clk,
  input  logic          reset,
  output logic [XW-1:0] h_cnt,
  output logic [YW-1:0] v_cnt,
  output logic          pix_req,
  output logic          frame_start,
  output logic          hs_raw,
  output logic          vs_raw,
  output logic [2:0]    bar_idx
);
  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [XW-1:0] H_LAST   = XW'(H_TOTAL - 1);
  localparam logic [YW-1:0] V_LAST   = YW'(V_TOTAL - 1);
  localparam logic [XW-1:0] H_ACT_C  = XW'(H_ACTIVE);
  localparam logic [YW-1:0] V_ACT_C  = YW'(V_ACTIVE);
  localparam logic [XW-1:0] HS_START = XW'(H_ACTIVE + H_FP);
  localparam logic [XW-1:0] HS_END   = XW'(H_ACTIVE + H_FP + H_SYNC - 1);
  localparam logic [YW-1:0] VS_START = YW'(V_ACTIVE + V_FP);
  localparam logic [YW-1:0] VS_END   = YW'(V_ACTIVE + V_FP + V_SYNC - 1);

  always_ff @(posedge pixel_clk or negedge reset) begin
    if (!reset) begin
      h_cnt <= '0;
      v_cnt <= '0;
    end else if (h_cnt == H_LAST) begin
      h_cnt <= '0;
      v_cnt <= (v_cnt == V_LAST) ? '0 : v_cnt + 1'b1;
    end else begin
      h_cnt <= h_cnt + 1'b1;
    end
  end

  // Gated by reset so the request/start strobes are quiet while held in reset
  // and valid in the very first cycle after release.
  assign pix_req     = reset && (h_cnt < H_ACT_C) && (v_cnt < V_ACT_C);
  assign frame_start = reset && (h_cnt == '0) && (v_cnt == '0);

  assign hs_raw = (h_cnt >= HS_START && h_cnt <= HS_END) ? HS_POL : ~HS_POL;
  assign vs_raw = (v_cnt >= VS_START && v_cnt <= VS_END) ? VS_POL : ~VS_POL;

  // Bar index = number of eighth-width thresholds passed; comparators, no divider
  always_comb begin
    bar_idx = '0;
    for (int k = 1; k < 8; k++)
      if (h_cnt >= XW'(k * H_ACTIVE / 8)) bar_idx = bar_idx + 3'd1;
  end

endmodule

// File: rtl/vga_output_stage.sv
// VGA output stage: timing core, PIPE_LAT delay line for req/syncs/bar index,
// frame-aligned mode latch and registered pixel mux.
module vga_output_stage
  import vga_pkg::*;
#(
  parameter int                  COLOR_W  = 8,
  parameter int                  H_ACTIVE = H_ACTIVE_D,
  parameter int                  H_FP     = H_FP_D,
  parameter int                  H_SYNC   = H_SYNC_D,
  parameter int                  H_BP     = H_BP_D,
  parameter int                  V_ACTIVE = V_ACTIVE_D,
  parameter int                  V_FP     = V_FP_D,
  parameter int                  V_SYNC   = V_SYNC_D,
  parameter int                  V_BP     = V_BP_D,
  parameter bit                  HS_POL   = 1'b0,
  parameter bit                  VS_POL   = 1'b0,
  parameter int                  PIPE_LAT = 1,
  parameter logic [COLOR_W-1:0]  FILL     = '0
) (
  input  logic               pixel_clk,
  input  logic               reset,
  input  logic [1:0]         mode,
  vga_if.master              pix,
  output logic [COLOR_W-1:0] rgb_out,
  output logic               de,
  output logic               h_sync,
  output logic               v_sync
);
  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int XW      = $clog2(H_TOTAL);
  localparam int YW      = $clog2(V_TOTAL);
  localparam dly_t DLY_IDLE = '{req: 1'b0, hs: ~HS_POL, vs: ~VS_POL, bar: 3'd0};

  logic [XW-1:0] h_cnt;
  logic [YW-1:0] v_cnt;
  logic          pix_req, frame_start, hs_raw, vs_raw;
  logic [2:0]    bar_idx;

  vga_timing_core #(
    .H_ACTIVE(H_ACTIVE), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
    .V_ACTIVE(V_ACTIVE), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP),
    .HS_POL(HS_POL), .VS_POL(VS_POL), .XW(XW), .YW(YW)
  ) u_core (
    .pixel_clk   (pixel_clk),
    .reset       (reset),
    .h_cnt       (h_cnt),
    .v_cnt       (v_cnt),
    .pix_req     (pix_req),
    .frame_start (frame_start),
    .hs_raw      (hs_raw),
    .vs_raw      (vs_raw),
    .bar_idx     (bar_idx)
  );

  assign pix.pix_x       = h_cnt;
  assign pix.pix_y       = v_cnt;
  assign pix.pix_req     = pix_req;
  assign pix.frame_start = frame_start;

  // dly_pipe[PIPE_LAT] lines up with the colour the controller returns this cycle
  dly_t raw;
  dly_t [PIPE_LAT:1] dly_pipe;
  dly_t tap;

  assign raw = '{req: pix_req, hs: hs_raw, vs: vs_raw, bar: bar_idx};
  assign tap = dly_pipe[PIPE_LAT];

  always_ff @(posedge pixel_clk or negedge reset) begin
    if (!reset) begin
      for (int i = 1; i <= PIPE_LAT; i++) dly_pipe[i] <= DLY_IDLE;
    end else begin
      dly_pipe[1] <= raw;
      for (int i = 2; i <= PIPE_LAT; i++) dly_pipe[i] <= dly_pipe[i-1];
    end
  end

  logic [7:0]         bar332;
  logic [COLOR_W-1:0] bar_c;
  assign bar332 = bar_color(tap.bar);

  generate
    if (COLOR_W == 8) begin : g_bar_eq
      assign bar_c = bar332;
    end else if (COLOR_W > 8) begin : g_bar_wide
      assign bar_c = {bar332, {(COLOR_W-8){1'b0}}};
    end else begin : g_bar_narrow
      assign bar_c = bar332[7 -: COLOR_W];
    end
  endgenerate

  mode_e mode_q;

  // Mode only changes at frame_start, so a frame is never split between two modes
  always_ff @(posedge pixel_clk or negedge reset) begin
    if (!reset) begin
      mode_q  <= MODE_PASS;
      rgb_out <= '0;
      de      <= 1'b0;
      h_sync  <= ~HS_POL;
      v_sync  <= ~VS_POL;
    end else begin
      if (frame_start) mode_q <= mode_e'(mode);
      de     <= tap.req;
      h_sync <= tap.hs;
      v_sync <= tap.vs;
      if (!tap.req) begin
        rgb_out <= '0;
      end else begin
        unique case (mode_q)
          MODE_PASS:  rgb_out <= pix.color_data;
          MODE_FILL:  rgb_out <= FILL;
          MODE_BARS:  rgb_out <= bar_c;
          MODE_BLANK: rgb_out <= '0;
          default:    rgb_out <= '0;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_vga_output_stage.sv
// Randomized bench for vga_output_stage on a reduced raster; expected outputs come from
// a cycle-index model (coordinates by div/mod, per-frame mode log, colour hash).
module tb_vga_output_stage;
  localparam int HA = 64, HFP = 4, HSY = 8, HBP = 4;
  localparam int VA = 16, VFP = 2, VSY = 2, VBP = 3;
  localparam int PL = 3;
  localparam int CW = 8;
  localparam logic [7:0] FILL = 8'h5A;
  localparam int HT = HA + HFP + HSY + HBP;
  localparam int VT = VA + VFP + VSY + VBP;
  localparam int FT = HT * VT;
  localparam int XW = $clog2(HT);
  localparam int YW = $clog2(VT);

  logic          pixel_clk = 1'b0;
  logic          reset = 1'b0;
  logic [1:0]    mode = 2'd0;
  logic [CW-1:0] rgb_out;
  logic          de, h_sync, v_sync;

  vga_if #(.XW(XW), .YW(YW), .COLOR_W(CW)) pix ();

  vga_output_stage #(
    .COLOR_W(CW), .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HSY), .H_BP(HBP),
    .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VSY), .V_BP(VBP),
    .HS_POL(1'b0), .VS_POL(1'b0), .PIPE_LAT(PL), .FILL(FILL)
  ) dut (
    .pixel_clk (pixel_clk),
    .reset     (reset),
    .mode      (mode),
    .pix       (pix),
    .rgb_out   (rgb_out),
    .de        (de),
    .h_sync    (h_sync),
    .v_sync    (v_sync)
  );

  always #5 pixel_clk = ~pixel_clk;

  int n_checks = 0;
  int n_errs   = 0;
  int n;            // cycles since reset release
  int salt;
  bit rand_mode;
  int frame_mode [0:15];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errs++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, n);
    end
  endtask

  function automatic bit in_active(input int s);
    return (s % HT) < HA && ((s / HT) % VT) < VA;
  endfunction

  function automatic logic [7:0] src_color(input int s);
    return 8'(((s % HT) ^ (((s / HT) % VT) * salt)));
  endfunction

  function automatic logic [7:0] bar_ref(input int x);
    logic [7:0] tbl [0:7] = '{8'hFF, 8'hFC, 8'h1F, 8'h1C, 8'hE3, 8'hE0, 8'h03, 8'h00};
    return tbl[x / (HA / 8)];
  endfunction

  // Output at cycle i shows the coordinate issued at i-PL-1
  function automatic logic [7:0] exp_rgb(input int i);
    int s = i - PL - 1;
    if (s < 0 || !in_active(s)) return 8'h00;
    case (frame_mode[s / FT])
      0:       return src_color(s);
      1:       return FILL;
      2:       return bar_ref(s % HT);
      default: return 8'h00;
    endcase
  endfunction

  function automatic bit exp_hs(input int i);
    int s = i - PL - 1;
    if (s < 0) return 1'b1;
    return !((s % HT) >= HA + HFP && (s % HT) < HA + HFP + HSY);
  endfunction

  function automatic bit exp_vs(input int i);
    int s = i - PL - 1;
    if (s < 0) return 1'b1;
    return !(((s / HT) % VT) >= VA + VFP && ((s / HT) % VT) < VA + VFP + VSY);
  endfunction

  function automatic bit exp_de(input int i);
    int s = i - PL - 1;
    return s >= 0 && in_active(s);
  endfunction

  task automatic check_reset_state(input string where);
    chk({where, "_rgb"}, 32'(rgb_out), 32'h0);
    chk({where, "_de"}, 32'(de), 32'h0);
    chk({where, "_hs"}, 32'(h_sync), 32'h1);
    chk({where, "_vs"}, 32'(v_sync), 32'h1);
    chk({where, "_req"}, 32'(pix.pix_req), 32'h0);
    chk({where, "_fs"}, 32'(pix.frame_start), 32'h0);
    chk({where, "_x"}, 32'(pix.pix_x), 32'h0);
  endtask

  task automatic check_cycle();
    int x = n % HT;
    int y = (n / HT) % VT;
    chk("pix_x", 32'(pix.pix_x), 32'(x));
    chk("pix_y", 32'(pix.pix_y), 32'(y));
    chk("pix_req", 32'(pix.pix_req), 32'(in_active(n)));
    chk("frame_start", 32'(pix.frame_start), 32'(x == 0 && y == 0));
    chk("rgb_out", 32'(rgb_out), 32'(exp_rgb(n)));
    chk("de", 32'(de), 32'(exp_de(n)));
    chk("h_sync", 32'(h_sync), 32'(exp_hs(n)));
    chk("v_sync", 32'(v_sync), 32'(exp_vs(n)));
    if (x == 0 && y == 0) frame_mode[n / FT] = int'(mode);
  endtask

  // Colour for cycle n answers the request issued PL cycles earlier; don't-care slots get X or junk
  task automatic drive();
    int s = n - PL;
    if (s >= 0 && in_active(s) && frame_mode[s / FT] == 0)
      pix.color_data = src_color(s);
    else if ($urandom_range(0, 1) == 0)
      pix.color_data = 'x;
    else
      pix.color_data = 8'($urandom);
    if (rand_mode) begin
      if ($urandom_range(0, 299) == 0) mode = 2'($urandom);
    end else if (n % FT == 5 * HT) begin
      mode = 2'((n / FT + 1) % 4);
    end
  endtask

  task automatic run(input int cycles);
    repeat (cycles) begin
      @(negedge pixel_clk);
      check_cycle();
      @(posedge pixel_clk);
      #1;
      n++;
      drive();
    end
  endtask

  task automatic release_reset();
    @(posedge pixel_clk);
    #1;
    reset = 1'b1;
    n = 0;
    foreach (frame_mode[k]) frame_mode[k] = 0;
    drive();
  endtask

  initial begin
    salt = int'($urandom_range(1, 255));
    n = 0;
    rand_mode = 1'b0;
    pix.color_data = '0;
    foreach (frame_mode[k]) frame_mode[k] = 0;

    repeat (5) begin
      @(negedge pixel_clk);
      check_reset_state("por");
    end

    // Deterministic mode schedule: each frame requests a new mode at line 5
    release_reset();
    run(5 * FT + (VA + VFP) * HT + HA + HFP + 2);

    // Async reset in the middle of both sync pulses
    reset = 1'b0;
    #1;
    check_reset_state("async");
    repeat (3) begin
      @(negedge pixel_clk);
      check_reset_state("held");
    end

    rand_mode = 1'b1;
    mode = 2'($urandom);
    release_reset();
    run(3 * FT + 10);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errs);
    $finish;
  end

endmodule
